sev_seg_scan_ctrl: RTL and testbench
====================================

Name: sev_seg_scan_ctrl

Overview:
Time-multiplexes one shared sev_seg_dec instance across NUM_DIGITS common-anode digits on the RTC display board. Each frame it presents each digit's BCD/hex nibble on dec_val and enables that digit's anode for a fixed dwell. A blank guard interval between digits suppresses ghosting. New display values arrive through a valid/ready handshake and are applied only at frame boundaries, so a frame never shows a torn time value.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant
DWELL_CYCLES, 50000, clk cycles each digit is lit (1 ms at 50 MHz)
BLANK_CYCLES, 500, clk cycles all anodes are off before each digit (>=1)
LZ_BLANK, 1, 1 = blank leading zeros; 0 = show all digits

Ports:
clk  input  1  system clock, 50 MHz, rising-edge
rst_n  input  1  asynchronous active-low reset
upd_data  input  4*NUM_DIGITS  new digit nibbles; [4i+3:4i] = digit i
upd_valid  input  1  upd_data valid
upd_ready  output  1  controller can accept an update
dec_val  output  4  nibble to sev_seg_dec.dec_val
dig_en_n  output  NUM_DIGITS  active-low anode enables, at most one low
frame_start  output  1  one-cycle pulse when digit 0's guard begins

Behaviour:
- Reset (async assert, sync-safe release): state=GUARD, idx=0, counter=0, active and pending registers = 0, pending_full=0, dig_en_n=all 1, dec_val=0, frame_start=0, upd_ready=1.
- All outputs are registered and update on the same rising edge.
- FSM states: GUARD, DWELL.
  - GUARD: dig_en_n=all 1; dec_val=active[idx]. Lasts BLANK_CYCLES cycles, then go to DWELL.
  - DWELL: dig_en_n[idx]=0 unless digit idx is blanked; dec_val held. Lasts DWELL_CYCLES cycles, then go to GUARD with idx+1.
  - idx wraps from NUM_DIGITS-1 to 0. Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES).
- frame_start is high exactly in the first GUARD cycle with idx=0. It also fires in the first cycle after reset release.
- Handshake:
  - upd_ready = ~pending_full.
  - Transfer occurs when upd_valid & upd_ready on a clock edge: pending<=upd_data, pending_full<=1.
  - upd_data is ignored while upd_ready=0.
- Frame boundary is the edge that moves from DWELL of idx NUM_DIGITS-1 to GUARD of idx 0. On that edge, if pending_full: active<=pending, pending_full<=0.
  - dec_val for the new frame's digit 0 uses the new active value on that same edge.
- Simultaneous accept and frame boundary on one edge: the boundary uses the old pending contents. Because pending_full=1 forces upd_ready=0, this cannot coincide with an accept. An accept on the boundary edge with pending empty is applied at the next frame boundary. There is no bypass.
- Leading-zero blanking (LZ_BLANK=1): digit i>0 is blanked when active[i] and every active[j] for j>i equal 0. Digit 0 is never blanked.
  - A blanked digit still occupies its guard and dwell slots, so frame timing is fixed; its enable just stays high.
- Nibbles 10..15 pass through unchanged; the decoder renders them as hex. Nonzero hex counts as nonzero for blanking.
- Reset asserted mid-frame takes effect immediately: all anodes off, pending update discarded.
- Counter width is clog2(max(DWELL_CYCLES,BLANK_CYCLES)). Counters never exceed their terminal count.

Test Plan:
Bench parameters: NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2 (frame = 24 cycles).
1. Reset release with no update -> frame_start at cycle 0 then every 24 cycles; dig_en_n = 1111 always (LZ_BLANK=1, all zero), except digit 0 low (1110) for cycles 2-5 with dec_val=0.
2. Push upd_data=16'h1234 mid-frame -> upd_ready drops for one frame. From the next frame: dig_en_n sequence 1110/1101/1011/0111, each low for 4 cycles after 2 all-high cycles; dec_val 4,3,2,1.
3. Push 16'h0050 -> digit 3 and digit 2 anodes never go low; digit 1 shows 5; digit 0 shows 0 and is lit. Repeat with LZ_BLANK=0 -> all four lit.
4. Hold upd_valid with 16'hAAAA then 16'h5555 back-to-back -> 16'h5555 accepted only after the boundary that applies AAAA; no frame ever mixes nibbles.
5. Assert rst_n low during digit 2 dwell with an update pending -> dig_en_n=1111 asynchronously; after release, display shows 0 (pending discarded) and upd_ready=1.
6. Every cycle of a 1000-cycle run -> at most one dig_en_n bit low; at least 2 all-high cycles between successive lit digits.

Source files
------------

// File: rtl/sev_seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder, with a blank guard before each digit.
// Latency: outputs registered; an accepted update shows from the next frame boundary (digit 0 guard).
// Backpressure: upd_ready is low while an update waits for the frame boundary; upd_data is ignored then.
module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  output logic [3:0]              dec_val,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_start
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {GUARD = 1'b0, DWELL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pend_full_q, pend_full_d;
  // High only for the first edge after reset release: the FSM holds GUARD/idx 0/count 0
  // so that cycle becomes the opening guard cycle of frame 0 and frame_start fires there.
  logic                  init_q;
  logic                  boundary;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank_d;
  logic [NUM_DIGITS-1:0] en_n_d;
  logic [3:0]            dec_d;
  logic                  fs_d;

  assign upd_ready = ~pend_full_q;

  // Next-state: guard/dwell sequencing, frame-boundary swap of pending into active, update accept.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    boundary    = 1'b0;
    if (!init_q) begin
      case (state_q)
        GUARD: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DWELL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = GUARD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
    // Boundary consumes the old pending value; an accept can only happen when pending is empty.
    if (boundary && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end
    if (upd_valid && !pend_full_q) begin
      pending_d   = upd_data;
      pend_full_d = 1'b1;
    end
  end

  // Output values for the next cycle, derived from the next state so they land on the same edge.
  always_comb begin
    zero_run = 1'b1;
    blank_d  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_d[4*i +: 4] == 4'd0);
      if (LZ_BLANK && (i > 0) && zero_run) blank_d[i] = 1'b1;
    end
    en_n_d = '1;
    if ((state_d == DWELL) && !blank_d[idx_d]) en_n_d[idx_d] = 1'b0;
    dec_d = active_d[{idx_d, 2'b00} +: 4];
    fs_d  = (state_d == GUARD) && (idx_d == '0) && (cnt_d == '0);
  end

  // FSM state, display registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GUARD;
      idx_q       <= '0;
      cnt_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      init_q      <= 1'b1;
      dig_en_n    <= '1;
      dec_val     <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      init_q      <= 1'b0;
      dig_en_n    <= en_n_d;
      dec_val     <= dec_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl: 4 digits, dwell 4, blank 2 (24-cycle frame).
// Two instances share stimulus: one with leading-zero blanking, one without.
// Frames are checked cycle by cycle against hand-computed enables, nibbles and ready.
module tb_sev_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] upd_data;
  logic        upd_valid;
  logic        upd_ready, upd_ready_b;
  logic [3:0]  dec_val, dec_val_b;
  logic [3:0]  dig_en_n, dig_en_n_b;
  logic        frame_start, frame_start_b;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sev_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .upd_data(upd_data), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .dec_val(dec_val), .dig_en_n(dig_en_n), .frame_start(frame_start));

  sev_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .upd_data(upd_data), .upd_valid(upd_valid), .upd_ready(upd_ready_b),
    .dec_val(dec_val_b), .dig_en_n(dig_en_n_b), .frame_start(frame_start_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk ncyc cycles of a frame starting at its cycle 0. val = displayed value, mlz/mnlz = which
  // digits light on each instance, vld/rdy = per-cycle valid drive and expected ready,
  // data is d0 before cycle sw_k and d1 from then on.
  task automatic check_frame(input logic [15:0] val, input logic [3:0] mlz, input logic [3:0] mnlz,
                             input logic [23:0] vld, input logic [23:0] rdy, input int sw_k,
                             input logic [15:0] d0, input logic [15:0] d1, input int ncyc);
    logic [3:0] e_a, e_b, onehot;
    for (int k = 0; k < ncyc; k++) begin
      int d, ph;
      d  = k / 6;
      ph = k % 6;
      onehot = 4'b0001 << d;
      e_a = (ph >= 2 && mlz[d])  ? ~onehot : 4'hF;
      e_b = (ph >= 2 && mnlz[d]) ? ~onehot : 4'hF;
      chk($sformatf("fs k=%0d", k),    frame_start,   (k == 0));
      chk($sformatf("fs_b k=%0d", k),  frame_start_b, (k == 0));
      chk($sformatf("dec k=%0d", k),   dec_val,       val[4*d +: 4]);
      chk($sformatf("dec_b k=%0d", k), dec_val_b,     val[4*d +: 4]);
      chk($sformatf("en k=%0d", k),    dig_en_n,      e_a);
      chk($sformatf("en_b k=%0d", k),  dig_en_n_b,    e_b);
      chk($sformatf("rdy k=%0d", k),   upd_ready,     rdy[k]);
      chk($sformatf("rdy_b k=%0d", k), upd_ready_b,   rdy[k]);
      upd_valid = vld[k];
      upd_data  = (k < sw_k) ? d0 : d1;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_a, prev_b;
    int         hi_a, hi_b;
    bit         seen_a, seen_b;

    rst_n = 1'b0; upd_valid = 1'b0; upd_data = 16'h0;
    repeat (3) tick();
    chk("rst en",  dig_en_n,   4'hF);
    chk("rst en_b", dig_en_n_b, 4'hF);
    chk("rst dec", dec_val,    4'h0);
    chk("rst fs",  frame_start, 1'b0);
    chk("rst rdy", upd_ready,  1'b1);
    rst_n = 1'b1;
    tick();

    // Idle frame: all zero, only digit 0 lit with blanking.
    check_frame(16'h0000, 4'b0001, 4'hF, 24'h0, 24'hFFFFFF, 24, 16'h0, 16'h0, 24);
    // Push 1234 mid-frame: ready drops until the boundary.
    check_frame(16'h0000, 4'b0001, 4'hF, 24'h000400, 24'h0007FF, 24, 16'h1234, 16'h1234, 24);
    check_frame(16'h1234, 4'hF, 4'hF, 24'h0, 24'hFFFFFF, 24, 16'h0, 16'h0, 24);
    // Push 0050.
    check_frame(16'h1234, 4'hF, 4'hF, 24'h000020, 24'h00003F, 24, 16'h0050, 16'h0050, 24);
    // 0050 shown: digits 3,2 blanked; back-to-back AAAA then 5555 held across the boundary.
    check_frame(16'h0050, 4'b0011, 4'hF, 24'hF00000, 24'h1FFFFF, 21, 16'hAAAA, 16'h5555, 24);
    // AAAA for a whole frame; 5555 accepted on the first edge of this frame.
    check_frame(16'hAAAA, 4'hF, 4'hF, 24'h000001, 24'h000001, 0, 16'h5555, 16'h5555, 24);
    // 5555 shown; queue 0900, then reset during digit 2 dwell.
    check_frame(16'h5555, 4'hF, 4'hF, 24'h000008, 24'h00000F, 0, 16'h0900, 16'h0900, 15);
    chk("d2 lit", dig_en_n, 4'b1011);
    upd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst en",   dig_en_n,   4'hF);
    chk("arst en_b", dig_en_n_b, 4'hF);
    chk("arst dec",  dec_val,    4'h0);
    chk("arst rdy",  upd_ready,  1'b1);
    chk("arst fs",   frame_start, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // Pending 0900 was discarded by reset.
    check_frame(16'h0000, 4'b0001, 4'hF, 24'h0, 24'hFFFFFF, 24, 16'h0, 16'h0, 24);

    // Long run: at most one anode low, at least two dark cycles between lit digits.
    prev_a = 4'hF; prev_b = 4'hF; hi_a = 0; hi_b = 0; seen_a = 0; seen_b = 0;
    for (int i = 0; i < 1000; i++) begin
      chk("one_hot",   ($countones(~dig_en_n) <= 1), 1);
      chk("one_hot_b", ($countones(~dig_en_n_b) <= 1), 1);
      if (dig_en_n != 4'hF) begin
        if (seen_a && dig_en_n != prev_a) chk("gap", (hi_a >= 2), 1);
        seen_a = 1; hi_a = 0;
      end else hi_a++;
      if (dig_en_n_b != 4'hF) begin
        if (seen_b && dig_en_n_b != prev_b) chk("gap_b", (hi_b >= 2), 1);
        seen_b = 1; hi_b = 0;
      end else hi_b++;
      prev_a = dig_en_n;
      prev_b = dig_en_n_b;
      upd_valid = (i == 0 || i == 400);
      upd_data  = (i < 200) ? 16'h0302 : 16'h1234;
      tick();
    end
    upd_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
